// File: rtl/sdrc_init_monitor.sv
//-----------------------------------------------------------------------------
// sdrc_init_monitor
//
// Passive observer of the SDRAM command pins. It decodes each command on the
// rising edge of sdram_clk and tracks the power-up initialisation sequence:
// NOP window -> precharge-all -> auto-refreshes -> load-mode-register ->
// sdr_init_done. It reports either a sticky pass or the first violation with
// a code. Every output is registered.
//
// Ports
//   sdram_clk         SDRAM clock; all sampling on the rising edge
//   sdram_resetn      asynchronous active-low reset
//   sdr_cke           clock enable; commands are decoded only when high
//   sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n   command pins
//   sdr_addr[12:0]    address pins (A10 = precharge-all, LMR payload)
//   sdr_init_done     controller init-complete flag
//   cfg_sdr_mode_reg  expected mode register value for LMR
//   mon_init_ok       sequence completed correctly (sticky while DONE)
//   mon_err           violation detected (sticky until reset)
//   mon_err_code[3:0] code of the first violation
//   mon_state[2:0]    checker state (PWRUP=0 .. ERROR=5)
//   mon_refresh_cnt   AREF commands counted, saturating at 15
//   mon_nop_cnt       power-up NOP cycles counted, saturating at 0xFFFF
//-----------------------------------------------------------------------------
`timescale 1ns/1ps
module sdrc_init_monitor #(
    parameter int unsigned T_PWRUP_CYC = 505,
    parameter int unsigned T_RP        = 3,
    parameter int unsigned T_RFC       = 7,
    parameter int unsigned N_REFRESH   = 2,
    parameter int unsigned T_DONE_MAX  = 16
) (
    input  logic        sdram_clk,
    input  logic        sdram_resetn,
    input  logic        sdr_cke,
    input  logic        sdr_cs_n,
    input  logic        sdr_ras_n,
    input  logic        sdr_cas_n,
    input  logic        sdr_we_n,
    input  logic [12:0] sdr_addr,
    input  logic        sdr_init_done,
    input  logic [12:0] cfg_sdr_mode_reg,
    output logic        mon_init_ok,
    output logic        mon_err,
    output logic [3:0]  mon_err_code,
    output logic [2:0]  mon_state,
    output logic [3:0]  mon_refresh_cnt,
    output logic [15:0] mon_nop_cnt
);

    localparam logic [2:0] ST_PWRUP     = 3'd0;
    localparam logic [2:0] ST_PRECHG    = 3'd1;
    localparam logic [2:0] ST_REFRESH   = 3'd2;
    localparam logic [2:0] ST_WAIT_DONE = 3'd3;
    localparam logic [2:0] ST_DONE      = 3'd4;
    localparam logic [2:0] ST_ERROR     = 3'd5;

    localparam logic [3:0] E_BAD_PWRUP  = 4'd1;
    localparam logic [3:0] E_PRE_A10    = 4'd2;
    localparam logic [3:0] E_TRP        = 4'd3;
    localparam logic [3:0] E_BAD_CMD    = 4'd4;
    localparam logic [3:0] E_TRFC       = 4'd5;
    localparam logic [3:0] E_MODE       = 4'd6;
    localparam logic [3:0] E_FEW_REF    = 4'd7;
    localparam logic [3:0] E_DONE_TMO   = 4'd8;
    localparam logic [3:0] E_DONE_EARLY = 4'd9;
    localparam logic [3:0] E_DONE_DROP  = 4'd10;

    localparam logic [15:0] PWRUP_CYC_L = 16'(T_PWRUP_CYC);
    localparam logic [7:0]  RP_L        = 8'(T_RP);
    localparam logic [7:0]  RFC_L       = 8'(T_RFC);
    localparam logic [3:0]  NREF_L      = 4'(N_REFRESH);
    localparam logic [7:0]  DONE_MAX_L  = 8'(T_DONE_MAX);

    logic [2:0]  rcw_s;
    logic        is_nop_s;
    logic        is_cmd_s;
    logic        is_pre_s;
    logic        is_aref_s;
    logic        is_lmr_s;
    logic        nop_ok_s;
    logic [7:0]  timer_inc_s;

    logic [2:0]  state_r;
    logic [2:0]  state_nxt_s;
    logic [3:0]  err_code_s;

    logic [15:0] nop_cnt_r;
    logic [3:0]  refresh_cnt_r;
    logic [7:0]  gap_r;
    logic [7:0]  timer_r;
    logic        init_ok_r;
    logic        err_r;
    logic [3:0]  err_code_r;

    logic [15:0] nop_cnt_nxt_s;
    logic [3:0]  refresh_cnt_nxt_s;
    logic [7:0]  gap_nxt_s;
    logic [7:0]  timer_nxt_s;
    logic        init_ok_nxt_s;
    logic        err_nxt_s;
    logic [3:0]  err_code_nxt_s;

    assign rcw_s       = {sdr_ras_n, sdr_cas_n, sdr_we_n};
    assign nop_ok_s    = (nop_cnt_r >= PWRUP_CYC_L);
    assign timer_inc_s = timer_r + 8'd1;

    // Command decode; with cke low nothing is decoded (neither NOP nor command)
    always_comb begin
        is_nop_s  = 1'b0;
        is_cmd_s  = 1'b0;
        is_pre_s  = 1'b0;
        is_aref_s = 1'b0;
        is_lmr_s  = 1'b0;
        if (sdr_cke) begin
            if (sdr_cs_n || (rcw_s == 3'b111)) begin
                is_nop_s = 1'b1;
            end else begin
                is_cmd_s = 1'b1;
                case (rcw_s)
                    3'b010:  is_pre_s  = 1'b1;
                    3'b001:  is_aref_s = 1'b1;
                    3'b000:  is_lmr_s  = 1'b1;
                    default: is_pre_s  = 1'b0; // ACT, RD, WR, BST
                endcase
            end
        end else begin
            is_nop_s = 1'b0;
        end
    end

    // State register
    always_ff @(posedge sdram_clk or negedge sdram_resetn) begin
        if (!sdram_resetn) begin
            state_r <= ST_PWRUP;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next state and violation detection; if-chains are ordered by ascending
    // code so that the lowest code wins when several violations coincide
    always_comb begin
        err_code_s  = 4'd0;
        state_nxt_s = state_r;
        case (state_r)
            ST_PWRUP: begin
                if (is_cmd_s && !(is_pre_s && nop_ok_s)) begin
                    err_code_s = E_BAD_PWRUP;
                end else if (is_pre_s && !sdr_addr[10]) begin
                    err_code_s = E_PRE_A10;
                end else if (sdr_init_done) begin
                    err_code_s = E_DONE_EARLY;
                end else if (is_pre_s) begin
                    state_nxt_s = ST_PRECHG;
                end else begin
                    state_nxt_s = ST_PWRUP;
                end
            end
            ST_PRECHG: begin
                if (is_aref_s && (gap_r < RP_L)) begin
                    err_code_s = E_TRP;
                end else if (is_cmd_s && !is_aref_s) begin
                    err_code_s = E_BAD_CMD;
                end else if (sdr_init_done) begin
                    err_code_s = E_DONE_EARLY;
                end else if (is_aref_s) begin
                    state_nxt_s = ST_REFRESH;
                end else begin
                    state_nxt_s = ST_PRECHG;
                end
            end
            ST_REFRESH: begin
                if (is_cmd_s && !is_aref_s && !is_lmr_s) begin
                    err_code_s = E_BAD_CMD;
                end else if ((is_aref_s || is_lmr_s) && (gap_r < RFC_L)) begin
                    err_code_s = E_TRFC;
                end else if (is_lmr_s && (sdr_addr != cfg_sdr_mode_reg)) begin
                    err_code_s = E_MODE;
                end else if (is_lmr_s && (refresh_cnt_r < NREF_L)) begin
                    err_code_s = E_FEW_REF;
                end else if (sdr_init_done) begin
                    err_code_s = E_DONE_EARLY;
                end else if (is_lmr_s) begin
                    state_nxt_s = ST_WAIT_DONE;
                end else begin
                    state_nxt_s = ST_REFRESH;
                end
            end
            ST_WAIT_DONE: begin
                // A command beats a simultaneous init_done
                if (is_cmd_s) begin
                    err_code_s = E_BAD_CMD;
                end else if (sdr_init_done) begin
                    state_nxt_s = ST_DONE;
                end else if (timer_inc_s >= DONE_MAX_L) begin
                    err_code_s = E_DONE_TMO;
                end else begin
                    state_nxt_s = ST_WAIT_DONE;
                end
            end
            ST_DONE: begin
                if (!sdr_init_done) begin
                    err_code_s = E_DONE_DROP;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            ST_ERROR: begin
                state_nxt_s = ST_ERROR;
            end
            default: begin
                // Unreachable encoding: park in ERROR rather than guess
                state_nxt_s = ST_ERROR;
            end
        endcase
        if (err_code_s != 4'd0) begin
            state_nxt_s = ST_ERROR;
        end else begin
            state_nxt_s = state_nxt_s;
        end
    end

    // Next values of counters and flags; counters freeze once an error is taken
    always_comb begin
        nop_cnt_nxt_s     = nop_cnt_r;
        refresh_cnt_nxt_s = refresh_cnt_r;
        timer_nxt_s       = timer_r;
        init_ok_nxt_s     = (state_nxt_s == ST_DONE);
        err_nxt_s         = (state_nxt_s == ST_ERROR);
        if (is_cmd_s) begin
            gap_nxt_s = 8'd0;
        end else if (gap_r != 8'hFF) begin
            gap_nxt_s = gap_r + 8'd1;
        end else begin
            gap_nxt_s = gap_r;
        end
        if ((state_r != ST_ERROR) && (err_code_s != 4'd0)) begin
            err_code_nxt_s = err_code_s;
        end else begin
            err_code_nxt_s = err_code_r;
        end
        case (state_r)
            ST_PWRUP: begin
                if (is_nop_s && (state_nxt_s == ST_PWRUP) && (nop_cnt_r != 16'hFFFF)) begin
                    nop_cnt_nxt_s = nop_cnt_r + 16'd1;
                end else begin
                    nop_cnt_nxt_s = nop_cnt_r;
                end
            end
            ST_PRECHG: begin
                if (state_nxt_s == ST_REFRESH) begin
                    refresh_cnt_nxt_s = 4'd1;
                end else begin
                    refresh_cnt_nxt_s = refresh_cnt_r;
                end
            end
            ST_REFRESH: begin
                if (is_aref_s && (state_nxt_s == ST_REFRESH) && (refresh_cnt_r != 4'hF)) begin
                    refresh_cnt_nxt_s = refresh_cnt_r + 4'd1;
                end else begin
                    refresh_cnt_nxt_s = refresh_cnt_r;
                end
                if (state_nxt_s == ST_WAIT_DONE) begin
                    timer_nxt_s = 8'd0;
                end else begin
                    timer_nxt_s = timer_r;
                end
            end
            ST_WAIT_DONE: begin
                if (state_nxt_s == ST_WAIT_DONE) begin
                    timer_nxt_s = timer_inc_s;
                end else begin
                    timer_nxt_s = timer_r;
                end
            end
            default: begin
                timer_nxt_s = timer_r;
            end
        endcase
    end

    // Registered counters and result flags
    always_ff @(posedge sdram_clk or negedge sdram_resetn) begin
        if (!sdram_resetn) begin
            nop_cnt_r     <= 16'd0;
            refresh_cnt_r <= 4'd0;
            gap_r         <= 8'd0;
            timer_r       <= 8'd0;
            init_ok_r     <= 1'b0;
            err_r         <= 1'b0;
            err_code_r    <= 4'd0;
        end else begin
            nop_cnt_r     <= nop_cnt_nxt_s;
            refresh_cnt_r <= refresh_cnt_nxt_s;
            gap_r         <= gap_nxt_s;
            timer_r       <= timer_nxt_s;
            init_ok_r     <= init_ok_nxt_s;
            err_r         <= err_nxt_s;
            err_code_r    <= err_code_nxt_s;
        end
    end

    assign mon_init_ok     = init_ok_r;
    assign mon_err         = err_r;
    assign mon_err_code    = err_code_r;
    assign mon_state       = state_r;
    assign mon_refresh_cnt = refresh_cnt_r;
    assign mon_nop_cnt     = nop_cnt_r;

endmodule

// File: tb/tb_sdrc_init_monitor.sv
//-----------------------------------------------------------------------------
// tb_sdrc_init_monitor
//
// Drives command-pin sequences into sdrc_init_monitor. A reference model of
// the initialisation rules predicts the outputs after each clock edge; the
// prediction is queued and a separate monitor compares it against the DUT
// one time unit after the rising edge. Directed scenarios are followed by
// randomised sequences with occasional injected faults.
//-----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_sdrc_init_monitor;

    typedef struct packed {
        logic        ok;
        logic        err;
        logic [3:0]  code;
        logic [2:0]  st;
        logic [3:0]  rc;
        logic [15:0] nop;
    } exp_t;

    // {cs_n, ras_n, cas_n, we_n}
    localparam logic [3:0] C_NOP  = 4'b0111;
    localparam logic [3:0] C_DES  = 4'b1010;
    localparam logic [3:0] C_PRE  = 4'b0010;
    localparam logic [3:0] C_AREF = 4'b0001;
    localparam logic [3:0] C_LMR  = 4'b0000;
    localparam logic [3:0] C_ACT  = 4'b0011;
    localparam logic [3:0] C_RD   = 4'b0101;
    localparam logic [3:0] C_WR   = 4'b0100;
    localparam logic [3:0] C_BST  = 4'b0110;
    localparam logic [12:0] A10   = 13'h0400;

    logic        sdram_clk = 1'b0;
    logic        sdram_resetn = 1'b1;
    logic        sdr_cke = 1'b1;
    logic        sdr_cs_n = 1'b0;
    logic        sdr_ras_n = 1'b1;
    logic        sdr_cas_n = 1'b1;
    logic        sdr_we_n = 1'b1;
    logic [12:0] sdr_addr = 13'd0;
    logic        sdr_init_done = 1'b0;
    logic [12:0] cfg_sdr_mode_reg = 13'h033;
    logic        mon_init_ok;
    logic        mon_err;
    logic [3:0]  mon_err_code;
    logic [2:0]  mon_state;
    logic [3:0]  mon_refresh_cnt;
    logic [15:0] mon_nop_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    exp_t exp_q[$];
    exp_t mon_e;
    exp_t mon_a;

    // reference model state (phase numbers are the published mon_state codes)
    int m_phase, m_nop, m_ref, m_gap, m_wait, m_code;
    bit m_ok, m_err;

    sdrc_init_monitor dut (
        .sdram_clk        (sdram_clk),
        .sdram_resetn     (sdram_resetn),
        .sdr_cke          (sdr_cke),
        .sdr_cs_n         (sdr_cs_n),
        .sdr_ras_n        (sdr_ras_n),
        .sdr_cas_n        (sdr_cas_n),
        .sdr_we_n         (sdr_we_n),
        .sdr_addr         (sdr_addr),
        .sdr_init_done    (sdr_init_done),
        .cfg_sdr_mode_reg (cfg_sdr_mode_reg),
        .mon_init_ok      (mon_init_ok),
        .mon_err          (mon_err),
        .mon_err_code     (mon_err_code),
        .mon_state        (mon_state),
        .mon_refresh_cnt  (mon_refresh_cnt),
        .mon_nop_cnt      (mon_nop_cnt)
    );

    always #5 sdram_clk = ~sdram_clk;

    task automatic model_reset();
        m_phase = 0; m_nop = 0; m_ref = 0; m_gap = 0; m_wait = 0;
        m_code = 0; m_ok = 1'b0; m_err = 1'b0;
    endtask

    function automatic exp_t model_exp();
        exp_t e;
        e.ok   = m_ok;
        e.err  = m_err;
        e.code = 4'(m_code);
        e.st   = 3'(m_phase);
        e.rc   = 4'(m_ref);
        e.nop  = 16'(m_nop);
        return e;
    endfunction

    // One rising edge worth of the initialisation rules
    task automatic model_step(input logic cke, input logic [3:0] cmd,
                              input logic [12:0] addr, input logic done);
        int v[$];
        int kind; // 0 none (cke low), 1 NOP, 2 PRE, 3 AREF, 4 LMR, 5 other
        int lowest;
        bit is_cmd;
        if (m_phase == 5) return;
        if (!cke) kind = 0;
        else if (cmd[3] || cmd[2:0] == 3'b111) kind = 1;
        else if (cmd[2:0] == 3'b010) kind = 2;
        else if (cmd[2:0] == 3'b001) kind = 3;
        else if (cmd[2:0] == 3'b000) kind = 4;
        else kind = 5;
        is_cmd = (kind >= 2);
        case (m_phase)
            0: begin
                if (kind == 2) begin
                    if (m_nop < 505) v.push_back(1);
                    if (!addr[10]) v.push_back(2);
                end else if (is_cmd) v.push_back(1);
                if (done) v.push_back(9);
            end
            1: begin
                if (kind == 3 && m_gap < 3) v.push_back(3);
                if (is_cmd && kind != 3) v.push_back(4);
                if (done) v.push_back(9);
            end
            2: begin
                if ((kind == 3 || kind == 4) && m_gap < 7) v.push_back(5);
                if (is_cmd && kind != 3 && kind != 4) v.push_back(4);
                if (kind == 4 && addr != cfg_sdr_mode_reg) v.push_back(6);
                if (kind == 4 && m_ref < 2) v.push_back(7);
                if (done) v.push_back(9);
            end
            3: begin
                if (is_cmd) v.push_back(4);
                if (!done && m_wait + 1 >= 16) v.push_back(8);
            end
            default: begin
                if (!done) v.push_back(10);
            end
        endcase
        if (v.size() > 0) begin
            lowest = 99;
            foreach (v[i]) if (v[i] < lowest) lowest = v[i];
            m_phase = 5; m_err = 1'b1; m_ok = 1'b0; m_code = lowest;
        end else begin
            case (m_phase)
                0: begin
                    if (kind == 1 && m_nop < 65535) m_nop++;
                    if (kind == 2) m_phase = 1;
                end
                1: if (kind == 3) begin m_phase = 2; m_ref = 1; end
                2: begin
                    if (kind == 3 && m_ref < 15) m_ref++;
                    if (kind == 4) begin m_phase = 3; m_wait = 0; end
                end
                3: begin
                    if (done) begin m_phase = 4; m_ok = 1'b1; end
                    else m_wait++;
                end
                default: m_phase = m_phase;
            endcase
        end
        if (is_cmd) m_gap = 0;
        else if (m_gap < 255) m_gap++;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Called at a falling edge; applies one cycle and returns at the next falling edge
    task automatic cyc(input logic cke, input logic [3:0] cmd,
                       input logic [12:0] addr, input logic done);
        sdr_cke = cke;
        {sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n} = cmd;
        sdr_addr = addr;
        sdr_init_done = done;
        model_step(cke, cmd, addr, done);
        exp_q.push_back(model_exp());
        @(negedge sdram_clk);
    endtask

    task automatic nops(input int n, input logic done);
        for (int i = 0; i < n; i++) cyc(1'b1, (i % 7 == 3) ? C_DES : C_NOP, 13'($urandom), done);
    endtask

    task automatic do_reset();
        sdr_cke = 1'b1;
        {sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n} = C_NOP;
        sdr_init_done = 1'b0;
        sdram_resetn = 1'b0;
        #1;
        chk("rst_init_ok", 32'(mon_init_ok), 32'd0);
        chk("rst_err", 32'(mon_err), 32'd0);
        chk("rst_code", 32'(mon_err_code), 32'd0);
        chk("rst_state", 32'(mon_state), 32'd0);
        chk("rst_refresh", 32'(mon_refresh_cnt), 32'd0);
        chk("rst_nop", 32'(mon_nop_cnt), 32'd0);
        model_reset();
        repeat (2) begin
            exp_q.push_back(model_exp());
            @(negedge sdram_clk);
        end
        sdram_resetn = 1'b1;
    endtask

    task automatic to_refresh1();
        nops(505, 1'b0);
        cyc(1'b1, C_PRE, A10, 1'b0);
        nops(3, 1'b0);
        cyc(1'b1, C_AREF, 13'd0, 1'b0);
    endtask

    task automatic to_lmr(input logic [12:0] mode);
        to_refresh1();
        nops(7, 1'b0);
        cyc(1'b1, C_AREF, 13'd0, 1'b0);
        nops(7, 1'b0);
        cyc(1'b1, C_LMR, mode, 1'b0);
    endtask

    // Randomised cycle: occasionally corrupts the command, cke or init_done
    task automatic rcyc(input logic cke, input logic [3:0] cmd,
                        input logic [12:0] addr, input logic done);
        logic [3:0] c;
        logic k;
        logic d;
        c = cmd; k = cke; d = done;
        if ($urandom_range(0, 149) == 0) c = 4'($urandom);
        if ($urandom_range(0, 199) == 0) k = 1'b0;
        if ($urandom_range(0, 299) == 0) d = ~d;
        cyc(k, c, addr, d);
    endtask

    // Scoreboard monitor: one comparison per rising edge with a prediction queued
    initial begin
        forever begin
            @(posedge sdram_clk);
            #1;
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                mon_a = {mon_init_ok, mon_err, mon_err_code, mon_state, mon_refresh_cnt, mon_nop_cnt};
                n_checks++;
                if (mon_a !== mon_e) begin
                    n_fail++;
                    $display("FAIL outputs t=%0t: got ok=%0d err=%0d code=%0d st=%0d ref=%0d nop=%0d, expected ok=%0d err=%0d code=%0d st=%0d ref=%0d nop=%0d",
                             $time, mon_a.ok, mon_a.err, mon_a.code, mon_a.st, mon_a.rc, mon_a.nop,
                             mon_e.ok, mon_e.err, mon_e.code, mon_e.st, mon_e.rc, mon_e.nop);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge sdram_clk);

        // Legal sequence
        cfg_sdr_mode_reg = 13'h033;
        do_reset();
        to_lmr(13'h033);
        nops(7, 1'b0);
        cyc(1'b1, C_NOP, 13'd0, 1'b1);
        chk("legal_ok", 32'(mon_init_ok), 32'd1);
        chk("legal_state", 32'(mon_state), 32'd4);
        chk("legal_refresh", 32'(mon_refresh_cnt), 32'd2);
        chk("legal_nop", 32'(mon_nop_cnt), 32'd505);
        chk("legal_err", 32'(mon_err), 32'd0);
        cyc(1'b1, C_ACT, 13'd5, 1'b1);
        cyc(1'b1, C_WR, 13'd5, 1'b1);
        cyc(1'b1, C_RD, 13'd5, 1'b1);
        cyc(1'b1, C_BST, 13'd0, 1'b1);
        cyc(1'b1, C_PRE, A10, 1'b1);
        chk("done_cmds_state", 32'(mon_state), 32'd4);
        // init_done drop in DONE
        cyc(1'b1, C_NOP, 13'd0, 1'b0);
        chk("done_drop_code", 32'(mon_err_code), 32'd10);
        chk("done_drop_ok", 32'(mon_init_ok), 32'd0);

        // PRE too early
        do_reset();
        nops(500, 1'b0);
        cyc(1'b1, C_PRE, A10, 1'b0);
        chk("early_pre_err", 32'(mon_err), 32'd1);
        chk("early_pre_code", 32'(mon_err_code), 32'd1);
        chk("early_pre_state", 32'(mon_state), 32'd5);

        // AREF too close to previous AREF
        do_reset();
        to_refresh1();
        nops(4, 1'b0);
        cyc(1'b1, C_AREF, 13'd0, 1'b0);
        chk("trfc_code", 32'(mon_err_code), 32'd5);
        chk("trfc_refresh", 32'(mon_refresh_cnt), 32'd1);

        // Mode register mismatch, then init_done must not set ok
        do_reset();
        to_lmr(13'h032);
        chk("mode_code", 32'(mon_err_code), 32'd6);
        nops(3, 1'b1);
        chk("mode_ok_stays_0", 32'(mon_init_ok), 32'd0);
        chk("mode_code_held", 32'(mon_err_code), 32'd6);

        // init_done timeout, then asynchronous reset from ERROR
        do_reset();
        to_lmr(13'h033);
        nops(15, 1'b0);
        chk("tmo_not_yet", 32'(mon_state), 32'd3);
        nops(1, 1'b0);
        chk("tmo_code", 32'(mon_err_code), 32'd8);
        chk("tmo_state", 32'(mon_state), 32'd5);
        do_reset();

        // cke low inside the NOP window, then WR during REFRESH
        do_reset();
        nops(200, 1'b0);
        repeat (20) cyc(1'b0, C_PRE, A10, 1'b0);
        chk("cke_low_nop_hold", 32'(mon_nop_cnt), 32'd200);
        nops(305, 1'b0);
        chk("cke_nop_total", 32'(mon_nop_cnt), 32'd505);
        cyc(1'b1, C_PRE, A10, 1'b0);
        chk("cke_pre_state", 32'(mon_state), 32'd1);
        nops(3, 1'b0);
        cyc(1'b1, C_AREF, 13'd0, 1'b0);
        nops(7, 1'b0);
        cyc(1'b1, C_WR, 13'd0, 1'b0);
        chk("wr_in_refresh", 32'(mon_err_code), 32'd4);

        // PRE without A10
        do_reset();
        nops(505, 1'b0);
        cyc(1'b1, C_PRE, 13'd0, 1'b0);
        chk("pre_a10_code", 32'(mon_err_code), 32'd2);

        // init_done during PWRUP
        do_reset();
        nops(10, 1'b0);
        cyc(1'b1, C_NOP, 13'd0, 1'b1);
        chk("done_early_code", 32'(mon_err_code), 32'd9);

        // LMR after a single refresh
        do_reset();
        to_refresh1();
        nops(7, 1'b0);
        cyc(1'b1, C_LMR, cfg_sdr_mode_reg, 1'b0);
        chk("few_ref_code", 32'(mon_err_code), 32'd7);

        // AREF too soon after PRE, and a command together with init_done in WAIT_DONE
        do_reset();
        nops(505, 1'b0);
        cyc(1'b1, C_PRE, A10, 1'b0);
        nops(2, 1'b0);
        cyc(1'b1, C_AREF, 13'd0, 1'b0);
        chk("trp_code", 32'(mon_err_code), 32'd3);
        do_reset();
        to_lmr(13'h033);
        nops(2, 1'b0);
        cyc(1'b1, C_ACT, 13'd0, 1'b1);
        chk("cmd_with_done_code", 32'(mon_err_code), 32'd4);

        // Randomised sequences around the legal path
        for (int t = 0; t < 20; t++) begin
            int n;
            logic [12:0] mode;
            cfg_sdr_mode_reg = 13'($urandom);
            do_reset();
            n = 495 + $urandom_range(0, 20);
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 19) == 0) rcyc(1'b0, 4'($urandom), 13'($urandom), 1'b0);
                else rcyc(1'b1, C_NOP, 13'($urandom), 1'b0);
            end
            rcyc(1'b1, C_PRE, ($urandom_range(0, 9) != 0) ? A10 : 13'h0000, 1'b0);
            repeat ($urandom_range(1, 4)) rcyc(1'b1, C_NOP, 13'd0, 1'b0);
            rcyc(1'b1, C_AREF, 13'd0, 1'b0);
            repeat ($urandom_range(1, 3)) begin
                repeat ($urandom_range(5, 8)) rcyc(1'b1, C_NOP, 13'd0, 1'b0);
                rcyc(1'b1, C_AREF, 13'd0, 1'b0);
            end
            repeat ($urandom_range(5, 8)) rcyc(1'b1, C_NOP, 13'd0, 1'b0);
            mode = ($urandom_range(0, 4) == 0) ? (cfg_sdr_mode_reg ^ 13'h0001) : cfg_sdr_mode_reg;
            rcyc(1'b1, C_LMR, mode, 1'b0);
            repeat ($urandom_range(1, 18)) rcyc(1'b1, C_NOP, 13'd0, 1'b0);
            repeat (10) rcyc(1'b1, ($urandom_range(0, 1) == 0) ? C_NOP : C_RD, 13'($urandom), 1'b1);
            if ($urandom_range(0, 2) == 0) cyc(1'b1, C_NOP, 13'd0, 1'b0);
        end

        @(posedge sdram_clk);
        #2;
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
